fp_stream_mux: RTL
==================

// Module: fp_stream_mux
// PURPOSE
//  Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshake.
//  Merges operand streams (e.g. FP32 words from several producers) onto one operand bus
//  feeding the FP arithmetic units.
//  Two selection modes: fixed select (software-steered) or round-robin (fair merge).
//  Output is registered, with 1-cycle latency.
// PARAMETERS
//  WIDTH     32                   data word width in bits
//  CHANNELS  4                    number of input channels, >=2
//  SEL_W     $clog2(CHANNELS)     select/channel-index width (derived; do not override)
// PORTS
//  clk        in   1               single clock; all state updates on rising edge
//  rst        in   1               reset, synchronous, active-high
//  mode       in   1               0 = fixed select, 1 = round-robin
//  sel        in   SEL_W           channel chosen in fixed mode
//  in_valid   in   CHANNELS        per-channel valid
//  in_data    in   CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//  in_ready   out  CHANNELS        per-channel ready (at most one bit high)
//  out_valid  out  1               output word valid
//  out_data   out  WIDTH           output word
//  out_chan   out  SEL_W           index of the channel that supplied out_data
//  out_ready  in   1               downstream ready
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1,
//    skid empty. Any held or in-flight word is dropped. in_ready=0 while rst=1.
//  - Transfer on input i: in_valid[i] & in_ready[i]. Transfer on output: out_valid & out_ready.
//  - Grant (combinational, one-hot or zero):
//    - fixed: grant[sel] = in_valid[sel]. sel >= CHANNELS gives no grant.
//    - rr: first i with in_valid[i], searching rr_ptr+1, rr_ptr+2, ... with wrap mod CHANNELS.
//  - rr_ptr updates to the granted index only on an accepted input transfer.
//    It is unchanged in fixed mode and unchanged when nothing is accepted.
//  - Without skid: in_ready[i] = grant[i] & (~out_valid | out_ready).
//  - Accepted word appears on out_data/out_chan with out_valid=1 on the next cycle (latency 1).
//  - Stall (out_valid & ~out_ready): out_data and out_chan held stable; no input accepted.
//  - Simultaneous output transfer and input accept in the same cycle: the register is
//    overwritten with the new word; out_valid stays 1. Full throughput is 1 word/cycle.
//  - mode/sel changes take effect combinationally on the next grant. The registered word is
//    never altered.
//  - out_valid never depends combinationally on out_ready.
//  - No word is duplicated or lost except at reset.
// CONFIGURATION
//  FP_STREAM_MUX_SKID_EN defined:
//   - Adds a 1-entry skid register behind the output register.
//   - in_ready[i] = grant[i] & ~skid_full, with skid_full registered. No combinational path
//     from out_ready to in_ready.
//   - Word accepted while output is stalled goes to the skid; it moves to the output register
//     on the next output transfer.
//   - Latency stays 1 when the skid is empty. Order is preserved. Capacity is 2 words.
//  FP_STREAM_MUX_SKID_EN undefined:
//   - Behaviour as above. in_ready depends combinationally on out_ready.
// STRUCTURE
//  Package fp_mux_pkg:
//   - localparams MODE_FIXED=1'b0, MODE_RR=1'b1.
//   - function onehot_to_idx for the channel index.
//  Sub-module rr_arbiter #(CHANNELS): inputs req, ptr; outputs grant (one-hot), grant_idx.
//   Used for round-robin mode only.
//  Top level holds the fixed-select path, grant muxing, output register and optional skid.
// TESTING
//  1. Fixed mode, sel=2, all valid, data=ch*16'h1111, out_ready=1
//     -> every cycle out_data=32'h2222, out_chan=2, in_ready=4'b0100.
//  2. rr mode, all in_valid=1, out_ready=1, after reset
//     -> out_chan sequence 0,1,2,3,0; one word/cycle, no gaps.
//  3. rr mode, in_valid=4'b1010, rr_ptr=1
//     -> grants ch3, then ch1, then ch3; channels 0 and 2 never get in_ready.
//  4. Hold out_ready=0 for 3 cycles with a valid output word
//     -> out_data/out_chan stable; in_ready=0 (no skid), or exactly one more accept (skid);
//        no loss or duplication after release.
//  5. Assert rst mid-stream with out_valid=1
//     -> next cycle out_valid=0, out_data=0, out_chan=0; rr restarts at channel 0.
//  6. Fixed mode, CHANNELS=3, sel=3
//     -> in_ready=0, out_valid stays 0.

Source files
------------

// File: rtl/fp_mux_pkg.sv
// Shared constants and helpers for the fp_stream_mux operand-bus multiplexer.
package fp_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bound on the channel count that onehot_to_idx can encode.
  localparam int MAX_CHANNELS = 64;

  function automatic int onehot_to_idx(input logic [MAX_CHANNELS-1:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo CHANNELS.
module rr_arbiter
  import fp_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = SEL_W'((int'(ptr) + i) % CHANNELS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign grant_idx = SEL_W'(onehot_to_idx(MAX_CHANNELS'(grant)));

endmodule

// File: rtl/fp_stream_mux.sv
// N-channel registered stream mux (fixed select or round-robin), 1-cycle latency.
// Optional 1-entry skid behind the output register: define FP_STREAM_MUX_SKID_EN.
module fp_stream_mux
  import fp_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  // Handshake: a word moves when valid & ready are both high at a rising edge;
  // valid never waits on ready, and a presented word stays stable until taken.

  logic [CHANNELS-1:0] rr_grant, fix_grant, grant;
  logic [SEL_W-1:0]    rr_idx, grant_idx;
  logic [WIDTH-1:0]    word;
  logic                accept;

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // An out-of-range sel matches no channel, so it yields no grant.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fix_grant[i] = in_valid[i] && (int'(sel) == i);
    end
  end

  assign grant     = (mode == MODE_FIXED) ? fix_grant : rr_grant;
  assign grant_idx = (mode == MODE_FIXED) ? sel : rr_idx;

  always_comb begin
    word = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) word = in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef FP_STREAM_MUX_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_chan_q, skid_chan_d;

  assign in_ready = rst ? '0 : (grant & {CHANNELS{~skid_valid_q}});
  assign accept   = |in_ready;

  // A full skid implies a valid output word; it drains into the output register first.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_chan_d  = skid_chan_q;
    if (skid_valid_q) begin
      if (out_ready) begin
        out_data_d   = skid_data_q;
        out_chan_d   = skid_chan_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = word;
        out_chan_d  = grant_idx;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = word;
        skid_chan_d  = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_chan_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_chan_q  <= skid_chan_d;
    end
  end
`else
  assign in_ready = rst ? '0 : (grant & {CHANNELS{~out_valid_q | out_ready}});
  assign accept   = |in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = word;
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  assign rr_ptr_d = (accept && mode == MODE_RR) ? rr_idx : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= SEL_W'(CHANNELS - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
